neuron_act_stage: RTL and testbench

//  Downstream neighbour of the neuron accumulator. Takes each finished 22-bit neuron sum
//  (signed, 12 fractional bits), applies ReLU, rounds and saturates to the 8-bit signed

---
 rtl/neuron_act_stage.sv | 125 ++++++++++++
 tb/tb_neuron_act_stage.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_act_stage.sv
`default_nettype none
// ============================================================================
// Module      : neuron_act_stage
// Description : ReLU, round and saturate of neuron sums into 8-bit activations,
//               tagged with neuron index and buffered in a valid/ready FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module neuron_act_stage #(
  parameter int ACC_W      = 22,
  parameter int ACC_FRAC   = 12,
  parameter int OUT_W      = 8,
  parameter int OUT_FRAC   = 5,
  parameter int N_NEURONS  = 30,
  parameter int FIFO_DEPTH = 4,
  localparam int IDX_W     = $clog2(N_NEURONS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ACC_W-1:0] acc_in,
  input  logic             acc_valid,
  output logic             acc_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             layer_done,
  output logic [7:0]       sat_count
);

  localparam int SH    = ACC_FRAC - OUT_FRAC;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [ACC_W:0]     c_half     = (ACC_W+1)'(1) << (SH - 1);
  localparam logic [ACC_W:0]     c_out_max  = (ACC_W+1)'((2 ** (OUT_W - 1)) - 1);
  localparam logic [IDX_W-1:0]   c_last_idx = IDX_W'(N_NEURONS - 1);
  localparam logic [CNT_W:0]     c_depth    = (CNT_W+1)'(FIFO_DEPTH);

  logic             r_active;
  logic             r_s1_valid;
  logic [ACC_W-1:0] r_s1_acc;
  logic [IDX_W-1:0] r_s1_idx;
  logic [IDX_W-1:0] r_in_idx;
  logic [OUT_W-1:0] r_mem_data [FIFO_DEPTH];
  logic [IDX_W-1:0] r_mem_idx  [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [7:0]       r_sat_count;
  logic             r_layer_done;

  logic             w_xfer;
  logic             w_pop;
  logic [CNT_W:0]   w_inflight;
  logic [ACC_W:0]   w_sum;
  logic [ACC_W:0]   w_r;
  logic             w_neg;
  logic             w_sat;
  logic [OUT_W-1:0] w_result;

  // Slot accounting counts the staged sample too, so an accepted transfer
  // always finds room in the FIFO one cycle later.
  assign w_inflight = {1'b0, r_count} + {{CNT_W{1'b0}}, r_s1_valid};
  assign acc_ready  = r_active && (w_inflight < c_depth);
  assign w_xfer     = acc_valid && acc_ready;
  assign out_valid  = (r_count != '0);
  assign w_pop      = out_valid && out_ready;

  assign w_neg    = r_s1_acc[ACC_W-1];
  assign w_sum    = {1'b0, r_s1_acc} + c_half;
  assign w_r      = w_sum >> SH;
  assign w_sat    = !w_neg && (w_r > c_out_max);
  assign w_result = w_neg ? '0 : (w_sat ? c_out_max[OUT_W-1:0] : w_r[OUT_W-1:0]);

  assign out_data   = r_mem_data[r_rd_ptr];
  assign out_idx    = r_mem_idx[r_rd_ptr];
  assign layer_done = r_layer_done;
  assign sat_count  = r_sat_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_active     <= 1'b0;
      r_s1_valid   <= 1'b0;
      r_s1_acc     <= '0;
      r_s1_idx     <= '0;
      r_in_idx     <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_sat_count  <= '0;
      r_layer_done <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_data[i] <= '0;
        r_mem_idx[i]  <= '0;
      end
    end else begin
      r_active   <= 1'b1;
      r_s1_valid <= w_xfer;
      if (w_xfer) begin
        r_s1_acc <= acc_in;
        r_s1_idx <= r_in_idx;
        r_in_idx <= (r_in_idx == c_last_idx) ? '0 : r_in_idx + 1'b1;
      end
      if (r_s1_valid) begin
        r_mem_data[r_wr_ptr] <= w_result;
        r_mem_idx[r_wr_ptr]  <= r_s1_idx;
        r_wr_ptr             <= r_wr_ptr + 1'b1;
        if (w_sat && (r_sat_count != 8'hFF)) begin
          r_sat_count <= r_sat_count + 8'd1;
        end
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({r_s1_valid, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_layer_done <= w_pop && (out_idx == c_last_idx);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_neuron_act_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_neuron_act_stage
// Description : Directed vector table plus multi-cycle sequences for
//               neuron_act_stage with hand-computed expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_neuron_act_stage;

  logic        clk;
  logic        reset;
  logic [21:0] acc_in;
  logic        acc_valid;
  logic        acc_ready;
  logic [7:0]  out_data;
  logic [4:0]  out_idx;
  logic        out_valid;
  logic        out_ready;
  logic        layer_done;
  logic [7:0]  sat_count;

  neuron_act_stage dut (
    .clk        (clk),
    .reset      (reset),
    .acc_in     (acc_in),
    .acc_valid  (acc_valid),
    .acc_ready  (acc_ready),
    .out_data   (out_data),
    .out_idx    (out_idx),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .layer_done (layer_done),
    .sat_count  (sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [21:0] acc;
    logic [7:0]  exp_data;
    logic        exp_sat;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  int         n_sent = 0;
  int         n_pop  = 0;
  logic [7:0] got_data [$];
  logic [4:0] got_idx  [$];
  int         pulse_at [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // One clock: record handshakes seen before the edge, then advance to 1ns after it.
  task automatic step();
    logic x;
    logic p;
    x = acc_valid && acc_ready;
    p = out_valid && out_ready;
    if (p) begin
      got_data.push_back(out_data);
      got_idx.push_back(out_idx);
      n_pop++;
    end
    @(posedge clk);
    #1;
    if (x) n_sent++;
    if (layer_done) pulse_at.push_back(n_pop);
  endtask

  // Offers values first_val.. (acc = v<<7, i.e. output v) until total accepted or budget spent.
  task automatic send(input int total, input int first_val, input int budget, output int accepted);
    int start;
    int cyc;
    start = n_sent;
    cyc   = 0;
    while ((n_sent - start) < total && cyc < budget) begin
      acc_valid = 1'b1;
      acc_in    = 22'((first_val + n_sent - start) << 7);
      step();
      cyc++;
    end
    acc_valid = 1'b0;
    accepted  = n_sent - start;
  endtask

  task automatic drain(input int target, input int budget);
    int cyc;
    cyc = 0;
    while (got_data.size() < target && cyc < budget) begin
      step();
      cyc++;
    end
    chk("drain_count", 32'(got_data.size()), 32'(target));
  endtask

  task automatic do_reset();
    acc_valid = 1'b0;
    acc_in    = '0;
    reset     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    step();
    got_data.delete();
    got_idx.delete();
    pulse_at.delete();
    n_pop = 0;
  endtask

  vec_t vecs [12];
  int   sat_model;
  int   k;
  int   cyc;

  initial begin
    vecs[0]  = '{22'h001000, 8'h20, 1'b0};
    vecs[1]  = '{22'h3FF000, 8'h00, 1'b0};
    vecs[2]  = '{22'h000040, 8'h01, 1'b0};
    vecs[3]  = '{22'h00003F, 8'h00, 1'b0};
    vecs[4]  = '{22'h0000BF, 8'h01, 1'b0};
    vecs[5]  = '{22'h0000C0, 8'h02, 1'b0};
    vecs[6]  = '{22'h1FFFFF, 8'h7F, 1'b1};
    vecs[7]  = '{22'h003FBF, 8'h7F, 1'b0};
    vecs[8]  = '{22'h003FC0, 8'h7F, 1'b1};
    vecs[9]  = '{22'h000000, 8'h00, 1'b0};
    vecs[10] = '{22'h001F80, 8'h3F, 1'b0};
    vecs[11] = '{22'h200000, 8'h00, 1'b0};

    reset     = 1'b0;
    acc_valid = 1'b0;
    acc_in    = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_data",   32'(out_data),   32'h0);
    chk("rst_out_idx",    32'(out_idx),    32'h0);
    chk("rst_out_valid",  32'(out_valid),  32'h0);
    chk("rst_layer_done", 32'(layer_done), 32'h0);
    chk("rst_sat_count",  32'(sat_count),  32'h0);
    chk("rst_acc_ready",  32'(acc_ready),  32'h0);
    reset = 1'b1;
    #1;
    chk("release_acc_ready_pre_edge", 32'(acc_ready), 32'h0);
    @(posedge clk);
    #1;
    chk("release_acc_ready_post_edge", 32'(acc_ready), 32'h1);

    // Single-shot vectors: latency, ReLU, rounding and saturation boundaries.
    out_ready = 1'b1;
    sat_model = 0;
    for (int i = 0; i < 12; i++) begin
      acc_valid = 1'b1;
      acc_in    = vecs[i].acc;
      chk($sformatf("v%0d_acc_ready", i), 32'(acc_ready), 32'h1);
      step();
      acc_valid = 1'b0;
      chk($sformatf("v%0d_valid_after_1", i), 32'(out_valid), 32'h0);
      step();
      if (vecs[i].exp_sat) sat_model++;
      chk($sformatf("v%0d_valid_after_2", i), 32'(out_valid), 32'h1);
      chk($sformatf("v%0d_data", i), 32'(out_data), 32'(vecs[i].exp_data));
      chk($sformatf("v%0d_idx", i), 32'(out_idx), 32'(i));
      chk($sformatf("v%0d_sat_count", i), 32'(sat_count), 32'(sat_model));
      step();
      chk($sformatf("v%0d_popped", i), 32'(out_valid), 32'h0);
    end

    // 300 saturating inputs: counter must stick at 255.
    acc_valid = 1'b1;
    acc_in    = 22'h1FFFFF;
    k   = n_sent;
    cyc = 0;
    while ((n_sent - k) < 300 && cyc < 1000) begin
      step();
      cyc++;
    end
    acc_valid = 1'b0;
    chk("sat_stream_accepted", 32'(n_sent - k), 32'd300);
    repeat (4) step();
    chk("sat_count_sticks", 32'(sat_count), 32'd255);

    // Backpressure: only 4 in flight, then drain in order without loss.
    do_reset();
    out_ready = 1'b0;
    send(6, 1, 8, k);
    chk("bp_accepted_while_stalled", 32'(k), 32'd4);
    chk("bp_acc_ready_low", 32'(acc_ready), 32'h0);
    chk("bp_head_valid", 32'(out_valid), 32'h1);
    chk("bp_head_hold_data", 32'(out_data), 32'd1);
    chk("bp_head_hold_idx", 32'(out_idx), 32'd0);
    out_ready = 1'b1;
    chk("bp_no_same_cycle_ready", 32'(acc_ready), 32'h0);
    send(2, 5, 20, k);
    chk("bp_rest_accepted", 32'(k), 32'd2);
    drain(6, 30);
    for (int i = 0; i < 6 && i < got_data.size(); i++) begin
      chk($sformatf("bp_data%0d", i), 32'(got_data[i]), 32'(i + 1));
      chk($sformatf("bp_idx%0d", i), 32'(got_idx[i]), 32'(i));
    end
    repeat (3) step();
    chk("bp_no_duplicate", 32'(got_data.size()), 32'd6);

    // Two layers plus one: pulses after pops 30 and 60, index wraps.
    do_reset();
    out_ready = 1'b1;
    send(61, 1, 300, k);
    chk("layer_accepted", 32'(k), 32'd61);
    drain(61, 300);
    repeat (3) step();
    for (int i = 0; i < 61 && i < got_data.size(); i++) begin
      chk($sformatf("layer_data%0d", i), 32'(got_data[i]), 32'(i + 1));
      chk($sformatf("layer_idx%0d", i), 32'(got_idx[i]), 32'(i % 30));
    end
    chk("layer_pulse_count", 32'(pulse_at.size()), 32'd2);
    if (pulse_at.size() >= 2) begin
      chk("layer_pulse0_at_pop", 32'(pulse_at[0]), 32'd30);
      chk("layer_pulse1_at_pop", 32'(pulse_at[1]), 32'd60);
    end

    // Reset with results in flight: nothing emitted, index restarts at 0.
    do_reset();
    out_ready = 1'b1;
    send(8, 1, 40, k);
    out_ready = 1'b0;
    send(2, 9, 10, k);
    repeat (3) step();
    chk("midrst_fifo_nonempty", 32'(out_valid), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'h0);
    chk("midrst_out_data",  32'(out_data),  32'h0);
    chk("midrst_out_idx",   32'(out_idx),   32'h0);
    chk("midrst_acc_ready", 32'(acc_ready), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    step();
    chk("midrst_ready_back", 32'(acc_ready), 32'h1);
    chk("midrst_still_empty", 32'(out_valid), 32'h0);
    got_data.delete();
    got_idx.delete();
    out_ready = 1'b1;
    send(1, 42, 10, k);
    drain(1, 10);
    if (got_data.size() >= 1) begin
      chk("midrst_first_idx",  32'(got_idx[0]),  32'd0);
      chk("midrst_first_data", 32'(got_data[0]), 32'd42);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
